mem_port_arbiter: RTL and testbench

Arbitrates one single-ported unified memory between instruction fetch (IF) and the load/store path of the RV32I pipeline. Accepts one request per arbitration, registers it, drives the memory handshake, and returns a formatted response to the owner. Generates byte enables and store-data lanes, extracts and extends load data per `mem_funct3`, and flags misaligned accesses. Sits between the fetch/execute stages and the memory wrapper.

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 72 +++++++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the memory port arbiter
package rv32i_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } mem_owner_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store lanes, load extraction and access checks
module mem_lane_align
    import rv32i_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the returned word
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Lane enables, replicated store data and alignment/encoding checks by access size
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        err_o   = 1'b0;
        case (funct3_i[1:0])
            2'd0: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                err_o   = off_i[0];
            end
            2'd2: begin
                be_o  = 4'b1111;
                err_o = (off_i != 2'd0);
            end
            default: err_o = 1'b1;
        endcase
        // Stores only have signed-size encodings; loads reject the unused "LWU" slot
        if (we_i && funct3_i[2]) err_o = 1'b1;
        if (!we_i && funct3_i == 3'd6) err_o = 1'b1;
    end

    // Extend the selected load data; stores return zero
    always_comb begin
        rdata_o = 32'd0;
        if (!we_i) begin
            case (funct3_i)
                F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   rdata_o = {24'd0, byte_sel};
                F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
                F3_HU:   rdata_o = {16'd0, half_sel};
                F3_W:    rdata_o = rdata_i;
                default: rdata_o = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a single-ported unified memory
module mem_port_arbiter
    import rv32i_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state_q, state_d;
    mem_owner_e owner_q;
    logic       we_q;
    logic [2:0] funct3_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [3:0]  starve_q, starve_d;
    logic        drop_q, drop_d;
    logic        drop_hit;
    logic        if_rvalid_q, lsu_rvalid_q, lsu_err_q;
    logic [31:0] if_rdata_q, lsu_rdata_q;

    logic        idle;
    logic        if_win, lsu_win, accept;
    logic        al_we;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_err;

    assign idle    = (state_q == ARB_IDLE);
    assign if_win  = if_req_i && (!lsu_req_i || starve_q == LIMIT);
    assign lsu_win = lsu_req_i && !if_win;
    assign accept  = idle && (if_win || lsu_win);

    // While idle the aligner checks the incoming LSU request; afterwards it formats the response
    assign al_we  = idle ? lsu_we_i : we_q;
    assign al_f3  = idle ? lsu_funct3_i : funct3_q;
    assign al_off = idle ? lsu_addr_i[1:0] : addr_q[1:0];

    mem_lane_align u_align (
        .we_i     (al_we),
        .funct3_i (al_f3),
        .off_i    (al_off),
        .wdata_i  (lsu_wdata_i),
        .rdata_i  (mem_rdata_i),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata),
        .err_o    (al_err)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a faulty LSU request is answered straight from idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (if_win)                 state_d = ARB_ISSUE;
                else if (lsu_win && !al_err) state_d = ARB_ISSUE;
            end
            ARB_ISSUE: if (mem_gnt_i)    state_d = ARB_RESP;
            ARB_RESP:  if (mem_rvalid_i) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs; grants are masked during reset so every output reads zero
    always_comb begin
        if_gnt_o  = rst_n && idle && if_win;
        lsu_gnt_o = rst_n && idle && lsu_win;
        mem_req_o = (state_q == ARB_ISSUE);
    end

    // Starvation counter and fetch-drop flag next state
    always_comb begin
        starve_d = starve_q;
        drop_d   = drop_q;
        drop_hit = drop_q || (owner_q == OWN_IF && if_flush_i);
        case (state_q)
            ARB_IDLE: begin
                drop_d = if_win && if_flush_i;
                if (if_win)
                    starve_d = 4'd0;
                else if (lsu_win && if_req_i && starve_q != LIMIT)
                    starve_d = starve_q + 4'd1;
            end
            ARB_ISSUE: drop_d = drop_hit;
            ARB_RESP:  drop_d = mem_rvalid_i ? 1'b0 : drop_hit;
            default:   drop_d = 1'b0;
        endcase
    end

    // Counter and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
            drop_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    // Request capture at accept and one-cycle response pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_IF;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'd0;
            lsu_rvalid_q <= 1'b0;
            lsu_rdata_q  <= 32'd0;
            lsu_err_q    <= 1'b0;
        end else begin
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            if (accept) begin
                owner_q  <= if_win ? OWN_IF : OWN_LSU;
                we_q     <= if_win ? 1'b0 : lsu_we_i;
                funct3_q <= if_win ? F3_W : lsu_funct3_i;
                addr_q   <= if_win ? if_addr_i : lsu_addr_i;
                be_q     <= if_win ? 4'b1111 : al_be;
                wdata_q  <= if_win ? 32'd0 : al_wdata;
                if (lsu_win && al_err) begin
                    lsu_rvalid_q <= 1'b1;
                    lsu_err_q    <= 1'b1;
                    lsu_rdata_q  <= 32'd0;
                end
            end else if (state_q == ARB_RESP && mem_rvalid_i) begin
                if (owner_q == OWN_IF) begin
                    if_rvalid_q <= !drop_hit;
                    if_rdata_q  <= mem_rdata_i;
                end else begin
                    lsu_rvalid_q <= 1'b1;
                    lsu_rdata_q  <= al_rdata;
                end
            end
        end
    end

    assign if_rvalid_o  = if_rvalid_q;
    assign if_rdata_o   = if_rdata_q;
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign lsu_rdata_o  = lsu_rdata_q;
    assign lsu_err_o    = lsu_err_q;
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = {addr_q[31:2], 2'b00};
    assign mem_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic        if_flush_i = 1'b0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
    logic [2:0]  lsu_funct3_i = 3'd0;
    logic [31:0] lsu_addr_i = 32'd0, lsu_wdata_i = 32'd0;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One LSU transaction; memory grants in cycle 1 and responds in cycle 2
    task automatic lsu_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] word, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input logic exp_err);
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3;
        lsu_addr_i = addr; lsu_wdata_i = wdata;
        #1 check({tag, "_gnt"}, 32'(lsu_gnt_o), 32'd1);
        @(negedge clk);
        lsu_req_i = 1'b0;
        #1;
        if (exp_err) begin
            check({tag, "_noreq"}, 32'(mem_req_o), 32'd0);
            check({tag, "_rvalid"}, 32'(lsu_rvalid_o), 32'd1);
            check({tag, "_err"}, 32'(lsu_err_o), 32'd1);
            check({tag, "_rdata"}, lsu_rdata_o, 32'd0);
        end else begin
            check({tag, "_req"}, 32'(mem_req_o), 32'd1);
            check({tag, "_we"}, 32'(mem_we_o), 32'(we));
            check({tag, "_be"}, 32'(mem_be_o), 32'(exp_be));
            check({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
            if (we) check({tag, "_wdata"}, mem_wdata_o, exp_wdata);
            mem_gnt_i = 1'b1;
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = word;
            #1 check({tag, "_early"}, 32'(lsu_rvalid_o), 32'd0);
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            #1;
            check({tag, "_rvalid"}, 32'(lsu_rvalid_o), 32'd1);
            check({tag, "_rdata"}, lsu_rdata_o, exp_rdata);
            check({tag, "_err"}, 32'(lsu_err_o), 32'd0);
        end
    endtask

    // One fetch; optional flush while waiting for the memory response
    task automatic if_op(input string tag, input logic [31:0] addr, input logic [31:0] word,
                         input logic flush);
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = addr;
        #1 check({tag, "_gnt"}, 32'(if_gnt_o), 32'd1);
        @(negedge clk);
        if_req_i = 1'b0;
        #1;
        check({tag, "_req"}, 32'(mem_req_o), 32'd1);
        check({tag, "_be"}, 32'(mem_be_o), 32'hF);
        check({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0; if_flush_i = flush;
        @(negedge clk);
        if_flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = word;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        check({tag, "_rvalid"}, 32'(if_rvalid_o), flush ? 32'd0 : 32'd1);
        if (!flush) check({tag, "_rdata"}, if_rdata_o, word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_if;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_be", 32'(mem_be_o), 32'd0);
        check("rst_lsu_rvalid", 32'(lsu_rvalid_o), 32'd0);
        check("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
        rst_n = 1'b1;

        //      tag      we    f3    addr        wdata         word          be       wdata_exp     rdata_exp     err
        lsu_op("lw",   1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0);
        lsu_op("lb",   1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF0000, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0);
        lsu_op("lbu",  1'b0, 3'd4, 32'h103, 32'h0,        32'h80FF0000, 4'b1000, 32'h0,        32'h00000080, 1'b0);
        lsu_op("lh",   1'b0, 3'd1, 32'h102, 32'h0,        32'h80FF0000, 4'b1100, 32'h0,        32'hFFFF80FF, 1'b0);
        lsu_op("lhu",  1'b0, 3'd5, 32'h102, 32'h0,        32'h80FF0000, 4'b1100, 32'h0,        32'h000080FF, 1'b0);
        lsu_op("sh",   1'b1, 3'd1, 32'h206, 32'h1234ABCD, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0);
        lsu_op("sb",   1'b1, 3'd0, 32'h201, 32'h00000055, 32'hFFFFFFFF, 4'b0010, 32'h55555555, 32'h0,        1'b0);
        lsu_op("sw",   1'b1, 3'd2, 32'h208, 32'hCAFEF00D, 32'hFFFFFFFF, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0);
        lsu_op("lwmis",1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
        lsu_op("lhmis",1'b0, 3'd1, 32'h103, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
        lsu_op("ld3",  1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
        lsu_op("sbu",  1'b1, 3'd4, 32'h100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
        @(negedge clk);
        #1 check("err_pulse_end", 32'(lsu_rvalid_o), 32'd0);

        if_op("fetch", 32'h42, 32'h00A00093, 1'b0);
        if_op("fetch_flush", 32'h44, 32'h12345678, 1'b1);

        // Both requesters held high: four LSU wins, then IF, repeated
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h10;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'd2; lsu_addr_i = 32'h300;
        #1;
        for (int i = 0; i < 10; i++) begin
            exp_if = (i == 4 || i == 9);
            check($sformatf("starve_if_gnt%0d", i), 32'(if_gnt_o), 32'(exp_if));
            check($sformatf("starve_lsu_gnt%0d", i), 32'(lsu_gnt_o), 32'(!exp_if));
            @(negedge clk);
            mem_gnt_i = 1'b1;
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'(i);
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            #1;
            check($sformatf("starve_rvalid%0d", i),
                  32'(exp_if ? if_rvalid_o : lsu_rvalid_o), 32'd1);
        end
        if_req_i = 1'b0; lsu_req_i = 1'b0;

        // Reset asserted while waiting for the memory response
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'd2; lsu_addr_i = 32'h104;
        @(negedge clk);
        lsu_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        #1 check("pre_rst_addr", mem_addr_o, 32'h104);
        rst_n = 1'b0; lsu_req_i = 1'b1;
        #1;
        check("rst_mid_gnt", 32'(lsu_gnt_o), 32'd0);
        check("rst_mid_req", 32'(mem_req_o), 32'd0);
        check("rst_mid_addr", mem_addr_o, 32'd0);
        check("rst_mid_be", 32'(mem_be_o), 32'd0);
        @(negedge clk);
        lsu_req_i = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        check("late_lsu_rvalid", 32'(lsu_rvalid_o), 32'd0);
        check("late_if_rvalid", 32'(if_rvalid_o), 32'd0);
        check("late_mem_req", 32'(mem_req_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
